// File: rtl/fpu_addsub_seq.sv
// fpu_addsub_seq: multi-cycle IEEE-754 single-precision adder/subtractor.
// One FSM state per cycle: IDLE -> ALIGN -> ADD -> NORM -> [ROUND] -> PACK.
// Denormal inputs are flushed to zero; underflow flushes to signed zero.
// Build option: define FPU_ADDSUB_ROUND_EN to keep guard/round/sticky bits
// and add a round-to-nearest-even stage (latency 5 instead of 4).
module fpu_addsub_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        sub,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

`ifdef FPU_ADDSUB_ROUND_EN
    localparam int EXT = 3;  // guard, round, sticky
`else
    localparam int EXT = 0;
`endif
    localparam int SW = 24 + EXT;  // working significand width

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        ADD,
        NORM,
`ifdef FPU_ADDSUB_ROUND_EN
        ROUND,
`endif
        PACK
    } state_t;

    typedef struct packed {
        logic        sub;
        logic [31:0] a;
        logic [31:0] b;
    } req_t;

    state_t state, state_n;
    logic   busy_n, done_n;

    req_t              req;
    logic              sx, eff_sub, spec;
    logic [31:0]       spec_val;
    logic signed [9:0] ex;
    logic [SW-1:0]     sig_x, sig_y, nsig;
    logic [SW:0]       sum;

    // ALIGN combinational terms
    logic [7:0]    ea, eb, e_big, e_small, d;
    logic [30:0]   ma, mb;
    logic          sa, sb, a_big, nan_a, nan_b, inf_a, inf_b;
    logic [SW-1:0] sga, sgb, s_big, s_small, s_aln;
    logic          spec_c;
    logic [31:0]   spec_val_c;
`ifdef FPU_ADDSUB_ROUND_EN
    logic [SW+25:0] wide;
`endif

    // ADD / NORM / PACK combinational terms
    logic [SW:0]       sum_c;
    logic [4:0]        lz;
    logic [SW-1:0]     nsig_c;
    logic signed [9:0] ex_norm_c;
    logic [23:0]       mant;
    logic [31:0]       pack_c;

`ifdef FPU_ADDSUB_ROUND_EN
    logic [23:0]       rmant, rmant_c;
    logic [24:0]       m25;
    logic              round_up;
    logic signed [9:0] ex_rnd_c;
`endif

    // State register and handshake outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            busy  <= busy_n;
            done  <= done_n;
        end
    end

    // Next state: fixed walk through the pipeline, start only honoured in IDLE
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:  if (start) state_n = ALIGN;
            ALIGN: state_n = ADD;
            ADD:   state_n = NORM;
`ifdef FPU_ADDSUB_ROUND_EN
            NORM:  state_n = ROUND;
            ROUND: state_n = PACK;
`else
            NORM:  state_n = PACK;
`endif
            PACK:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
        done_n = (state == PACK);
    end

    // Unpack, order by magnitude, align smaller operand, detect specials
    always_comb begin
        ea    = req.a[30:23];
        eb    = req.b[30:23];
        sa    = req.a[31];
        sb    = req.b[31] ^ req.sub;  // effective sign of B
        ma    = (ea == 8'd0) ? 31'd0 : req.a[30:0];
        mb    = (eb == 8'd0) ? 31'd0 : req.b[30:0];
        sga   = (ea == 8'd0) ? '0 : (SW'({1'b1, req.a[22:0]}) << EXT);
        sgb   = (eb == 8'd0) ? '0 : (SW'({1'b1, req.b[22:0]}) << EXT);
        a_big = (ma >= mb);
        s_big   = a_big ? sga : sgb;
        s_small = a_big ? sgb : sga;
        e_big   = a_big ? ea : eb;
        e_small = a_big ? eb : ea;
        d       = e_big - e_small;
`ifdef FPU_ADDSUB_ROUND_EN
        // Everything shifted past the round bit collapses into sticky
        wide  = {s_small, 26'd0} >> d;
        s_aln = wide[SW+25:26];
        s_aln[0] = s_aln[0] | (|wide[25:0]);
`else
        s_aln = s_small >> d;
`endif
        if (d >= 8'd26) s_aln = '0;

        nan_a = (ea == 8'hFF) && (req.a[22:0] != 23'd0);
        nan_b = (eb == 8'hFF) && (req.b[22:0] != 23'd0);
        inf_a = (ea == 8'hFF) && (req.a[22:0] == 23'd0);
        inf_b = (eb == 8'hFF) && (req.b[22:0] == 23'd0);
        spec_c     = nan_a | nan_b | inf_a | inf_b;
        spec_val_c = 32'h7FC0_0000;
        if (!(nan_a || nan_b || (inf_a && inf_b && (sa != sb)))) begin
            if (inf_a) spec_val_c = {sa, 8'hFF, 23'd0};
            else       spec_val_c = {sb, 8'hFF, 23'd0};
        end
    end

    // Significand add/subtract; X >= Y so the difference never goes negative
    always_comb begin
        if (eff_sub) sum_c = {1'b0, sig_x} - {1'b0, sig_y};
        else         sum_c = {1'b0, sig_x} + {1'b0, sig_y};
    end

    // Normalize: one-bit right shift on carry, else shift up to the leading one
    always_comb begin
        lz = 5'd0;
        for (int i = 0; i < SW; i++)
            if (sum[i]) lz = 5'(SW - 1 - i);
        if (sum[SW]) begin
            nsig_c    = sum[SW:1];
`ifdef FPU_ADDSUB_ROUND_EN
            nsig_c[0] = sum[1] | sum[0];
`endif
            ex_norm_c = ex + 10'sd1;
        end else begin
            nsig_c    = sum[SW-1:0] << lz;
            ex_norm_c = ex - $signed({5'd0, lz});
        end
    end

`ifdef FPU_ADDSUB_ROUND_EN
    // Round to nearest even; a mantissa carry renormalizes by one place
    always_comb begin
        round_up = nsig[2] & (nsig[1] | nsig[0] | nsig[3]);
        m25      = {1'b0, nsig[SW-1:3]} + {24'd0, round_up};
        if (m25[24]) begin
            rmant_c  = m25[24:1];
            ex_rnd_c = ex + 10'sd1;
        end else begin
            rmant_c  = m25[23:0];
            ex_rnd_c = ex;
        end
    end
    assign mant = rmant;
`else
    assign mant = nsig;
`endif

    // Final packing; a clear hidden bit means the significand went to zero
    always_comb begin
        if (spec)                   pack_c = spec_val;
        else if (!mant[23])         pack_c = 32'h0000_0000;
        else if (ex <= 10'sd0)      pack_c = {sx, 31'd0};
        else if (ex >= 10'sd255)    pack_c = {sx, 8'hFF, 23'd0};
        else                        pack_c = {sx, ex[7:0], mant[22:0]};
    end

    // Datapath registers, each loaded in the state that produces them
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req      <= '0;
            sx       <= 1'b0;
            eff_sub  <= 1'b0;
            spec     <= 1'b0;
            spec_val <= '0;
            ex       <= '0;
            sig_x    <= '0;
            sig_y    <= '0;
            sum      <= '0;
            nsig     <= '0;
`ifdef FPU_ADDSUB_ROUND_EN
            rmant    <= '0;
`endif
            result   <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    req.sub <= sub;
                    req.a   <= op_a;
                    req.b   <= op_b;
                end
                ALIGN: begin
                    sx       <= a_big ? sa : sb;
                    eff_sub  <= sa ^ sb;
                    ex       <= $signed({2'b00, e_big});
                    sig_x    <= s_big;
                    sig_y    <= s_aln;
                    spec     <= spec_c;
                    spec_val <= spec_val_c;
                end
                ADD:  sum <= sum_c;
                NORM: begin
                    nsig <= nsig_c;
                    ex   <= ex_norm_c;
                end
`ifdef FPU_ADDSUB_ROUND_EN
                ROUND: begin
                    rmant <= rmant_c;
                    ex    <= ex_rnd_c;
                end
`endif
                PACK: result <= pack_c;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/fpu_addsub_seq.md
FPU_ADDSUB_SEQ -- requirements
Module: fpu_addsub_seq

Interface
REQ-001 clk  input  1  single clock, all state updates on its rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 start  input  1  request pulse, sampled only while busy=0.
REQ-004 sub  input  1  0 = A+B, 1 = A-B; captured with start.
REQ-005 op_a  input  32  IEEE-754 single operand A; captured with start.
REQ-006 op_b  input  32  IEEE-754 single operand B; captured with start.
REQ-007 busy  output  1  high from the edge that accepts start until done is asserted.
REQ-008 done  output  1  one-cycle pulse, result valid.
REQ-009 result  output  32  registered IEEE-754 single result, held until next done.

Function
REQ-010 FSM states SHALL be IDLE, ALIGN, ADD, NORM, (ROUND), PACK; one state per cycle; no stalls.
REQ-011 IDLE with start=1 SHALL capture operands, set busy, and go to ALIGN; start in any other state SHALL be ignored.
REQ-012 ALIGN SHALL unpack (hidden 1 when exp!=0), swap so that operand X has the larger magnitude, and right-shift Y's significand by exp difference, saturating the shift at 26 (Y becomes 0).
REQ-013 ADD SHALL add significands (25-bit) when effective signs match (sign_a ^ sign_b ^ sub = 0), else subtract Y from X; result sign = sign of X.
REQ-014 NORM SHALL right-shift by 1 and increment exponent on carry-out; otherwise left-shift to leading one and subtract shift count (0..24) from exponent in one cycle.
REQ-015 PACK SHALL register result, pulse done, clear busy, return to IDLE; done is high exactly 4 cycles after the accepting edge (5 with REQ-024).
REQ-016 Zero significand after ADD SHALL give result 0x00000000 (+0).
REQ-017 Exponent falling to <=0 after normalization SHALL flush to signed zero; exponent >=255 SHALL give signed infinity (exp=255, fraction=0).
REQ-018 Input exp=0 SHALL be treated as zero (denormals flushed).
REQ-019 Any NaN input, or inf minus inf in effective operation, SHALL give 0x7FC00000; otherwise an inf input SHALL give that inf with its effective sign.
REQ-020 start asserted in the same cycle as done SHALL be ignored (busy still 1 that cycle... busy clears on the done edge); start accepted only when sampled in IDLE.

Reset
REQ-021 reset=1 SHALL force, asynchronously: state=IDLE, busy=0, done=0, result=0x00000000, all operand/working registers=0.
REQ-022 reset mid-operation SHALL abandon the operation with no done pulse; first start after reset release is accepted normally.

Configuration
REQ-023 Macro FPU_ADDSUB_ROUND_EN selects rounding.
REQ-024 Defined: ALIGN keeps guard/round/sticky bits, an extra ROUND state applies round-to-nearest-even (renormalizing on mantissa carry), latency 5 cycles.
REQ-025 Undefined: shifted-out bits discarded (truncation), no ROUND state, latency 4 cycles.

Verification
REQ-026 op_a=0x3F800000, op_b=0x3F800000, sub=0 -> result=0x40000000, done 4 cycles after start (5 with macro).
REQ-027 op_a=0x3FC00000, op_b=0x3F800000, sub=1 -> result=0x3F000000; op_a=0x40400000, op_b=0x40400000, sub=1 -> result=0x00000000.
REQ-028 op_a=0x7F7FFFFF, op_b=0x7F7FFFFF, sub=0 -> result=0x7F800000; op_a=0x7F800000, op_b=0x7F800000, sub=1 -> 0x7FC00000.
REQ-029 op_a=0x3F800000, op_b=0x33800001, sub=0 -> 0x3F800000 without macro; 0x3F800001 with macro.
REQ-030 start held high for 10 cycles -> exactly two done pulses (cycles 4 and 9 without macro); operands changed while busy do not affect result.
REQ-031 reset asserted in NORM state -> busy=0, done=0, result=0 immediately; no done pulse follows; next request completes correctly.
